// File: rtl/dark_socv.sv
// Bring-up SoC top: sends a fixed banner over UART 8N1 once per reset, then echoes
// every correctly framed received byte back through a small FIFO.
module dark_socv #(
    parameter int BOARD_CK   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic XCLK,
    input  logic XRES,
    input  logic UART_RXD,
    output logic UART_TXD
);
    localparam int DIV = (BOARD_CK + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [3:0]    BANNER_LEN = 4'd10;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    // Reset asserts asynchronously everywhere, deasserts on the second clock edge.
    logic [1:0] rst_sync_reg;
    logic       rst_n;
    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) rst_sync_reg <= 2'b00;
        else       rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_n = rst_sync_reg[1];

    logic rxd_meta_reg, rxd_sync_reg, rxd_prev_reg;
    logic [3:0] boot_cnt_reg, banner_idx_reg;
    logic       boot_done, banner_active, avail;
    logic [7:0] banner_byte, src_byte;

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW:0] count_reg;
    logic        push, pop, rx_push, tx_load, full;

    tx_state_t tx_state_reg, tx_state_next;
    logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0]    tx_bit_reg, tx_bit_next;
    logic [7:0]    tx_shift_reg, tx_shift_next;
    logic          txd_reg, txd_next, tx_tick;

    rx_state_t rx_state_reg, rx_state_next;
    logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]    rx_bit_reg, rx_bit_next;
    logic [7:0]    rx_shift_reg, rx_shift_next;
    logic          rx_tick;

    always_comb begin
        banner_byte = 8'h00;
        case (banner_idx_reg)
            4'd0: banner_byte = 8'h44;
            4'd1: banner_byte = 8'h61;
            4'd2: banner_byte = 8'h72;
            4'd3: banner_byte = 8'h6B;
            4'd4: banner_byte = 8'h53;
            4'd5: banner_byte = 8'h6F;
            4'd6: banner_byte = 8'h43;
            4'd7: banner_byte = 8'h56;
            4'd8: banner_byte = 8'h0D;
            4'd9: banner_byte = 8'h0A;
            default: banner_byte = 8'h00;
        endcase
    end

    // Boot delay saturates at 15 so the first start bit lands 16 clocks after release.
    assign boot_done     = &boot_cnt_reg;
    assign banner_active = banner_idx_reg != BANNER_LEN;
    assign full          = count_reg == FULL_CNT;
    assign avail         = boot_done && (banner_active || count_reg != '0);
    assign src_byte      = banner_active ? banner_byte : fifo_mem[rd_ptr_reg];
    assign pop           = tx_load && !banner_active;
    assign push          = rx_push && (!full || pop);

    always_ff @(posedge XCLK or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_reg   <= 1'b1;
            rxd_sync_reg   <= 1'b1;
            rxd_prev_reg   <= 1'b1;
            boot_cnt_reg   <= '0;
            banner_idx_reg <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            rxd_meta_reg <= UART_RXD;
            rxd_sync_reg <= rxd_meta_reg;
            rxd_prev_reg <= rxd_sync_reg;
            if (!boot_done) boot_cnt_reg <= boot_cnt_reg + 4'd1;
            if (tx_load && banner_active) banner_idx_reg <= banner_idx_reg + 4'd1;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge XCLK) begin
        if (push) fifo_mem[wr_ptr_reg] <= rx_shift_reg;
    end

    assign tx_tick = tx_cnt_reg == DIV_LAST;

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_tick ? '0 : tx_cnt_reg + 1'b1;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        txd_next      = txd_reg;
        tx_load       = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                tx_cnt_next = '0;
                if (avail) tx_load = 1'b1;
            end
            TX_START: if (tx_tick) begin
                tx_state_next = TX_DATA;
                txd_next      = tx_shift_reg[0];
                tx_bit_next   = '0;
            end
            TX_DATA: if (tx_tick) begin
                if (tx_bit_reg == 3'd7) begin
                    tx_state_next = TX_STOP;
                    txd_next      = 1'b1;
                end else begin
                    tx_bit_next   = tx_bit_reg + 3'd1;
                    tx_shift_next = tx_shift_reg >> 1;
                    txd_next      = tx_shift_reg[1];
                end
            end
            TX_STOP: if (tx_tick) begin
                if (avail) tx_load = 1'b1;
                else       tx_state_next = TX_IDLE;
            end
            default: tx_state_next = TX_IDLE;
        endcase
        // Loading from STOP chains frames with no idle gap.
        if (tx_load) begin
            tx_state_next = TX_START;
            tx_cnt_next   = '0;
            tx_shift_next = src_byte;
            txd_next      = 1'b0;
        end
    end

    always_ff @(posedge XCLK or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            txd_reg      <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            txd_reg      <= txd_next;
        end
    end
    assign UART_TXD = txd_reg;

    assign rx_tick = rx_cnt_reg == DIV_LAST;

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_tick ? '0 : rx_cnt_reg + 1'b1;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_push       = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                rx_cnt_next = '0;
                if (rxd_prev_reg && !rxd_sync_reg) rx_state_next = RX_START;
            end
            RX_START: if (rx_cnt_reg == HALF_LAST) begin
                rx_cnt_next = '0;
                rx_bit_next = '0;
                rx_state_next = rxd_sync_reg ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_tick) begin
                rx_shift_next = {rxd_sync_reg, rx_shift_reg[7:1]};
                if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
                else                    rx_bit_next = rx_bit_reg + 3'd1;
            end
            RX_STOP: if (rx_tick) begin
                rx_push       = rxd_sync_reg;
                rx_state_next = rxd_sync_reg ? RX_IDLE : RX_WAIT;
            end
            RX_WAIT: begin
                rx_cnt_next = '0;
                if (rxd_sync_reg) rx_state_next = RX_IDLE;
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge XCLK or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end
endmodule

// File: tb/tb_dark_socv.sv
// Directed bench for dark_socv at 16 clocks per bit: banner, echo, framing error,
// glitch rejection, mid-banner reset and FIFO overflow during the banner.
module tb_dark_socv;
    localparam int DIV = 16;

    logic XCLK = 1'b0;
    logic XRES = 1'b1;
    logic UART_RXD = 1'b1;
    logic UART_TXD;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] banner [10] = '{8'h44, 8'h61, 8'h72, 8'h6B, 8'h53,
                                8'h6F, 8'h43, 8'h56, 8'h0D, 8'h0A};

    dark_socv #(.BOARD_CK(1600000), .BAUD(100000), .FIFO_DEPTH(4)) dut (
        .XCLK(XCLK), .XRES(XRES), .UART_RXD(UART_RXD), .UART_TXD(UART_TXD)
    );

    always #5 XCLK = ~XCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for a start bit on TXD and decodes one frame, sampling mid-bit.
    task automatic recv(input int timeout, output logic ok, output logic [7:0] b);
        int n;
        ok = 1'b0;
        b  = 8'h00;
        n  = 0;
        while (UART_TXD !== 1'b0 && n < timeout) begin
            @(negedge XCLK);
            n++;
        end
        if (UART_TXD !== 1'b0) return;
        repeat (DIV / 2) @(negedge XCLK);
        if (UART_TXD !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge XCLK);
            b[i] = UART_TXD;
        end
        repeat (DIV) @(negedge XCLK);
        ok = (UART_TXD === 1'b1);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            UART_RXD = f[i];
            repeat (DIV) @(negedge XCLK);
        end
        UART_RXD = 1'b1;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic ok;
        logic [7:0] b;
        recv(40 * DIV, ok, b);
        check({tag, "_frame"}, {31'd0, ok}, 32'd1);
        check(tag, {24'd0, b}, {24'd0, exp});
    endtask

    task automatic expect_silence(input string tag);
        logic ok;
        logic [7:0] b;
        recv(25 * DIV, ok, b);
        check(tag, {31'd0, ok}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lows;
        #1 XRES = 1'b0;
        repeat (20) @(negedge XCLK);
        check("reset_txd", {31'd0, UART_TXD}, 32'd1);
        XRES = 1'b1;
        n = 0;
        while (UART_TXD !== 1'b0 && n < 100) begin
            @(negedge XCLK);
            n++;
        end
        check("boot_delay", {31'd0, (n >= 16 && n <= 20)}, 32'd1);
        for (int k = 0; k < 10; k++) expect_byte($sformatf("banner%0d", k), banner[k]);

        lows = 0;
        repeat (30 * DIV) begin
            @(negedge XCLK);
            if (UART_TXD !== 1'b1) lows++;
        end
        check("idle_after_banner", lows, 0);

        fork
            send(8'hA5, 1'b1);
            expect_byte("echo_a5", 8'hA5);
        join

        send(8'h3C, 1'b0);
        expect_silence("framing_err_dropped");
        fork
            send(8'h55, 1'b1);
            expect_byte("echo_55", 8'h55);
        join

        @(negedge XCLK);
        UART_RXD = 1'b0;
        repeat (3) @(negedge XCLK);
        UART_RXD = 1'b1;
        expect_silence("glitch_ignored");

        XRES = 1'b0;
        repeat (5) @(negedge XCLK);
        XRES = 1'b1;
        for (int k = 0; k < 3; k++) expect_byte($sformatf("pre_reset%0d", k), banner[k]);
        n = 0;
        while (UART_TXD !== 1'b0 && n < 4 * DIV) begin
            @(negedge XCLK);
            n++;
        end
        repeat (5 * DIV + DIV / 2) @(negedge XCLK);
        check("pre_reset_bit4", {31'd0, UART_TXD}, 32'd0);
        XRES = 1'b0;
        #1;
        check("reset_async_txd", {31'd0, UART_TXD}, 32'd1);
        repeat (5) @(negedge XCLK);
        check("reset_hold_txd", {31'd0, UART_TXD}, 32'd1);
        XRES = 1'b1;

        fork
            begin
                repeat (5) @(negedge XCLK);
                for (int v = 1; v <= 6; v++) send(8'(v), 1'b1);
            end
            for (int k = 0; k < 10; k++) expect_byte($sformatf("restart%0d", k), banner[k]);
        join
        for (int v = 1; v <= 4; v++) expect_byte($sformatf("queued%0d", v), 8'(v));
        expect_silence("overflow_dropped");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
